// File: rtl/tap_prog_sequencer.sv
// rtl/tap_prog_sequencer.sv - streams a host-loaded coefficient buffer into a target tap port
// and waits for the target's done flag, with a bounded timeout.
module tap_prog_sequencer #(
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_ADDR_WIDTH   = 8,
  parameter int G_DONE_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr,
  input  logic [G_TAP_WIDTH-1:0]  wr_data,
  input  logic                    wr_en,
  input  logic [G_ADDR_WIDTH:0]   num_taps,
  input  logic                    start,
  output logic [G_TAP_WIDTH-1:0]  tap_dout,
  output logic                    tap_dout_valid,
  input  logic                    tap_dout_ready,
  input  logic                    tap_done_in,
  output logic                    busy,
  output logic                    prog_done,
  output logic                    timeout_err,
  output logic [G_ADDR_WIDTH:0]   tap_count
);

  localparam int DEPTH = 1 << G_ADDR_WIDTH;
  localparam int CW    = G_ADDR_WIDTH + 1;
  localparam int TW    = $clog2(G_DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_TAPS = {1'b1, {G_ADDR_WIDTH{1'b0}}};
  localparam logic [TW-1:0] TMR_LAST = TW'(G_DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           num_taps_q, num_taps_d;
  logic [CW-1:0]           tap_count_q, tap_count_d;
  logic                    prog_done_q, prog_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [G_TAP_WIDTH-1:0]  mem [DEPTH];
  logic [G_TAP_WIDTH-1:0]  rdata_q;

  logic                    clr;
  logic                    busy_w;
  logic                    start_ok;
  logic                    xfer;
  logic                    last_xfer;
  logic                    rd_en;
  logic [CW-1:0]           tap_count_inc;
  logic [G_ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    clr           = reset | ~enable;
    busy_w        = (state_q == S_FETCH) | (state_q == S_STREAM) | (state_q == S_WAIT_DONE);
    start_ok      = start & (num_taps != '0) & (num_taps <= MAX_TAPS) &
                    ((state_q == S_IDLE) | (state_q == S_COMPLETE));
    tap_count_inc = tap_count_q + CW'(1);
    xfer          = (state_q == S_STREAM) & tap_dout_ready;
    last_xfer     = xfer & (tap_count_inc == num_taps_q);
    // Read ahead: the RAM address tracks the tap that will be on the output next
    // cycle, so a held stall re-reads the same (write-protected) entry.
    rd_addr       = xfer ? tap_count_inc[G_ADDR_WIDTH-1:0] : tap_count_q[G_ADDR_WIDTH-1:0];
    rd_en         = (state_q == S_FETCH) | ((state_q == S_STREAM) & ~last_xfer);
  end

  always_comb begin
    state_d       = state_q;
    num_taps_d    = num_taps_q;
    tap_count_d   = tap_count_q;
    prog_done_d   = prog_done_q;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;
    case (state_q)
      S_IDLE, S_COMPLETE: begin
        if (start_ok) begin
          num_taps_d    = num_taps;
          tap_count_d   = '0;
          prog_done_d   = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          tap_count_d = tap_count_inc;
        end
        if (last_xfer) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tap_done_in) begin
          prog_done_d = 1'b1;
          state_d     = S_COMPLETE;
        end else if (timer_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_IDLE;
      num_taps_q    <= '0;
      tap_count_q   <= '0;
      prog_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      num_taps_q    <= num_taps_d;
      tap_count_q   <= tap_count_d;
      prog_done_q   <= prog_done_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_w) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  always_comb begin
    tap_dout       = rdata_q;
    tap_dout_valid = (state_q == S_STREAM);
    busy           = busy_w;
    prog_done      = prog_done_q;
    timeout_err    = timeout_err_q;
    tap_count      = tap_count_q;
  end

endmodule

// File: tb/tb_tap_prog_sequencer.sv
// tb/tb_tap_prog_sequencer.sv - directed self-checking bench for tap_prog_sequencer.
module tb_tap_prog_sequencer;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [8:0]  num_taps;
  logic        start;
  logic [15:0] tap_dout;
  logic        tap_dout_valid;
  logic        tap_dout_ready;
  logic        tap_done_in;
  logic        busy;
  logic        prog_done;
  logic        timeout_err;
  logic [8:0]  tap_count;

  int n_cmp = 0;
  int n_bad = 0;

  tap_prog_sequencer #(
    .G_TAP_WIDTH   (16),
    .G_ADDR_WIDTH  (8),
    .G_DONE_TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .num_taps      (num_taps),
    .start         (start),
    .tap_dout      (tap_dout),
    .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready),
    .tap_done_in   (tap_done_in),
    .busy          (busy),
    .prog_done     (prog_done),
    .timeout_err   (timeout_err),
    .tap_count     (tap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [8:0]  n;
    logic        ready;
    logic        done;
    logic        exp_valid;
    logic        chk_dout;
    logic [15:0] exp_dout;
    logic        exp_busy;
    logic        exp_prog;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [15:0] pat(input int k);
    if (k < 3) return 16'(k + 1);
    return 16'(k * 935) ^ 16'h5C00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_stream(input int n, input bit rnd, input int stop_at);
    int          idx;
    bit          stalled;
    logic [15:0] held;
    idx     = 0;
    stalled = 1'b0;
    held    = '0;
    num_taps = 9'(n);
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_prog_clear", prog_done, 0);
    chk("start_to_clear", timeout_err, 0);
    chk("fetch_valid", tap_dout_valid, 0);
    tick();
    for (int cyc = 0; cyc < 4 * n + 20; cyc++) begin
      if (idx == n || (stop_at > 0 && idx == stop_at)) break;
      tap_dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_valid", tap_dout_valid, 1);
        chk("stall_data", tap_dout, held);
      end
      if (!rnd) chk("no_bubble", tap_dout_valid, 1);
      stalled = 1'b0;
      if (tap_dout_valid) begin
        if (tap_dout_ready) begin
          chk($sformatf("data[%0d]", idx), tap_dout, pat(idx));
          idx++;
        end else begin
          stalled = 1'b1;
          held    = tap_dout;
        end
      end
      tick();
    end
    tap_dout_ready = 1'b0;
    if (stop_at == 0) begin
      chk("xfer_total", idx, n);
      chk("tap_count_end", tap_count, n);
      chk("valid_after_last", tap_dout_valid, 0);
      chk("busy_wait_done", busy, 1);
    end else begin
      chk("xfer_partial", idx, stop_at);
    end
  endtask

  task automatic finish_done();
    tap_done_in = 1'b1;
    tick();
    tap_done_in = 1'b0;
    chk("done_prog", prog_done, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    wr_addr        = '0;
    wr_data        = '0;
    wr_en          = 1'b0;
    num_taps       = '0;
    start          = 1'b0;
    tap_dout_ready = 1'b0;
    tap_done_in    = 1'b0;

    tbl[0] = '{1'b1, 9'd3,   1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 9'd0};
    tbl[1] = '{1'b0, 9'd3,   1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 9'd0};
    tbl[2] = '{1'b0, 9'd3,   1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 9'd1};
    tbl[3] = '{1'b0, 9'd3,   1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 9'd2};
    tbl[4] = '{1'b0, 9'd3,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 9'd3};
    tbl[5] = '{1'b0, 9'd3,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd3};
    tbl[6] = '{1'b0, 9'd3,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd3};
    tbl[7] = '{1'b1, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd3};
    tbl[8] = '{1'b1, 9'd257, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd3};

    tick();
    tick();
    chk("rst_valid", tap_dout_valid, 0);
    chk("rst_dout", tap_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog", prog_done, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_count", tap_count, 0);
    reset = 1'b0;

    for (int k = 0; k < 256; k++) begin
      wr_addr = 8'(k);
      wr_data = pat(k);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Basic 3-tap run, done ignored mid-stream, illegal starts from COMPLETE.
    for (int i = 0; i < 9; i++) begin
      start          = tbl[i].start;
      num_taps       = tbl[i].n;
      tap_dout_ready = tbl[i].ready;
      tap_done_in    = tbl[i].done;
      tick();
      chk($sformatf("tbl%0d_valid", i), tap_dout_valid, tbl[i].exp_valid);
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), tap_dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_prog", i), prog_done, tbl[i].exp_prog);
      chk($sformatf("tbl%0d_count", i), tap_count, tbl[i].exp_cnt);
    end
    start          = 1'b0;
    tap_dout_ready = 1'b0;
    tap_done_in    = 1'b0;

    run_stream(129, 1'b1, 0);
    finish_done();

    // Timeout with no done.
    run_stream(4, 1'b0, 0);
    repeat (TO - 1) tick();
    chk("to_before", timeout_err, 0);
    chk("to_before_busy", busy, 1);
    tick();
    chk("to_set", timeout_err, 1);
    chk("to_busy", busy, 0);
    chk("to_prog", prog_done, 0);

    num_taps = 9'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_start_busy", busy, 0);
    chk("zero_start_to_kept", timeout_err, 1);

    // Done on the terminal-count cycle wins.
    run_stream(4, 1'b0, 0);
    repeat (TO - 1) tick();
    tap_done_in = 1'b1;
    tick();
    tap_done_in = 1'b0;
    chk("prio_prog", prog_done, 1);
    chk("prio_to", timeout_err, 0);
    chk("prio_busy", busy, 0);

    // start and writes while busy are ignored.
    num_taps = 9'd8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    num_taps = 9'd2;
    start    = 1'b1;
    wr_addr  = 8'd1;
    wr_data  = 16'hDEAD;
    wr_en    = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("busy_start_valid", tap_dout_valid, 1);
    chk("busy_start_dout", tap_dout, pat(0));
    tap_dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ign_valid[%0d]", k), tap_dout_valid, 1);
      chk($sformatf("ign_data[%0d]", k), tap_dout, pat(k));
      tick();
    end
    tap_dout_ready = 1'b0;
    chk("ign_count", tap_count, 8);
    chk("ign_valid_end", tap_dout_valid, 0);
    finish_done();

    // Reset after the 5th of 10 transfers.
    run_stream(10, 1'b0, 5);
    reset          = 1'b1;
    tap_dout_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", tap_dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", tap_count, 0);
    chk("mid_rst_dout", tap_dout, 0);
    chk("mid_rst_prog", prog_done, 0);
    chk("mid_rst_to", timeout_err, 0);
    tick();
    chk("mid_rst_no_xfer", tap_dout_valid, 0);
    chk("mid_rst_count2", tap_count, 0);
    tap_dout_ready = 1'b0;
    run_stream(10, 1'b0, 0);
    finish_done();

    // enable low acts as reset.
    run_stream(3, 1'b0, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("en_busy", busy, 0);
    chk("en_count", tap_count, 0);
    tap_done_in = 1'b1;
    tick();
    tap_done_in = 1'b0;
    chk("en_done_ignored", prog_done, 0);

    // Full buffer, no wrap.
    run_stream(256, 1'b0, 0);
    chk("full_last_dout", tap_dout, pat(255));
    finish_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tap_prog_sequencer.md
TAP_PROG_SEQUENCER -- requirements
Module: tap_prog_sequencer

Interface
REQ-001 Parameter G_TAP_WIDTH, default 16: width of each coefficient word.
REQ-002 Parameter G_ADDR_WIDTH, default 8: log2 of the coefficient buffer depth (256 entries).
REQ-003 Parameter G_DONE_TIMEOUT, default 1024: number of cycles to wait for the target done flag.
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  when low, the block behaves as if reset.
REQ-007 wr_addr  in  G_ADDR_WIDTH  host buffer write address.
REQ-008 wr_data  in  G_TAP_WIDTH  host buffer write data.
REQ-009 wr_en  in  1  host buffer write strobe.
REQ-010 num_taps  in  G_ADDR_WIDTH+1  number of taps to stream, unsigned.
REQ-011 start  in  1  single-cycle request to begin streaming.
REQ-012 tap_dout  out  G_TAP_WIDTH  coefficient sent to the target tap_din port.
REQ-013 tap_dout_valid  out  1  valid flag for tap_dout.
REQ-014 tap_dout_ready  in  1  ready flag from the target.
REQ-015 tap_done_in  in  1  done flag from the target (tap_din_done).
REQ-016 busy  out  1  high from an accepted start until COMPLETE or a timeout.
REQ-017 prog_done  out  1  sticky flag: the target reported done.
REQ-018 timeout_err  out  1  sticky flag: done was not seen within G_DONE_TIMEOUT cycles.
REQ-019 tap_count  out  G_ADDR_WIDTH+1  number of taps accepted in the current or last run.

Function
REQ-020 Buffer SHALL be a 2^G_ADDR_WIDTH x G_TAP_WIDTH RAM with synchronous read; a write occurs on wr_en only when busy=0, and wr_en while busy=1 SHALL be ignored.
REQ-021 States SHALL be IDLE, FETCH, STREAM, WAIT_DONE, COMPLETE.
REQ-022 IDLE: start=1 with 1 <= num_taps <= 2^G_ADDR_WIDTH SHALL latch num_taps, clear tap_count/prog_done/timeout_err, set busy, and go to FETCH.
REQ-023 IDLE or COMPLETE: start with num_taps=0 or num_taps > 2^G_ADDR_WIDTH SHALL be ignored (no state or flag change).
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 FETCH: lasts exactly 1 cycle (reads address 0), then goes to STREAM.
REQ-026 Latency: start sampled at cycle N -> tap_dout_valid=1 with buffer[0] at cycle N+2.
REQ-027 STREAM: tap_dout SHALL present buffer[k] for k = 0..num_taps-1, in ascending order.
REQ-028 tap_dout and tap_dout_valid SHALL stay stable while tap_dout_valid=1 and tap_dout_ready=0.
REQ-029 A transfer SHALL occur on a cycle with valid=1 and ready=1, and SHALL increment tap_count.
REQ-030 With ready held high, one tap SHALL transfer per cycle with no bubbles (read-ahead required).
REQ-031 On the transfer of the last tap, tap_dout_valid SHALL deassert on the next cycle and the state SHALL go to WAIT_DONE.
REQ-032 WAIT_DONE: a timeout counter starts at 0 and increments each cycle.
REQ-033 WAIT_DONE: tap_done_in=1 SHALL go to COMPLETE, set prog_done=1 and clear busy.
REQ-034 WAIT_DONE: counter reaching G_DONE_TIMEOUT-1 with tap_done_in=0 SHALL set timeout_err=1, clear busy and go to IDLE.
REQ-035 If tap_done_in=1 and the timeout terminal count occur on the same cycle, done SHALL take priority.
REQ-036 tap_done_in asserted during FETCH or STREAM SHALL be ignored.
REQ-037 COMPLETE SHALL behave as IDLE for host writes and start; prog_done SHALL hold until the next accepted start.
REQ-038 The address counter SHALL not wrap; num_taps = 2^G_ADDR_WIDTH SHALL stream every entry exactly once.

Reset
REQ-039 On reset=1 or enable=0, the state SHALL become IDLE and tap_dout_valid, busy, prog_done, timeout_err and tap_count SHALL all be 0; tap_dout SHALL be 0.
REQ-040 Buffer contents SHALL NOT be cleared by reset.
REQ-041 Reset mid-STREAM SHALL drop valid on the next cycle, with no further transfers.

Verification
REQ-042 Write buffer[0..2]=0x0001,0x0002,0x0003; num_taps=3; start; ready=1 -> taps 1,2,3 on consecutive cycles from start+2; tap_count=3; done_in pulse -> prog_done=1, busy=0.
REQ-043 num_taps=129 with ready toggling 1/0 randomly -> exactly 129 transfers, in order, data stable under stall, tap_count=129.
REQ-044 Stream 4 taps and never assert done_in -> timeout_err=1 exactly G_DONE_TIMEOUT cycles after entering WAIT_DONE; busy=0; prog_done=0.
REQ-045 start with num_taps=0, then start during STREAM, then wr_en during STREAM -> all ignored; buffer is unchanged.
REQ-046 reset after the 5th of 10 transfers -> valid=0 next cycle; all flags 0; a new start restreams from buffer[0] with the original data.
REQ-047 num_taps=256 with ready=1 -> 256 transfers, last data = buffer[255], no wrap.
